complex_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-DSP complex multiplier (fixed 6-cycle pipeline, no reset, no backpressure) between NUM_REQ requesters. It accepts one operand set per cycle via valid/ready, registers it into the multiplier, and carries a requester tag alongside the multiplier pipeline. The product is returned on a shared response bus qualified by a one-hot valid. It also provides drain control (halt/idle) and a sticky alignment-error flag.

---
 rtl/complex_mult_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_complex_mult_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_arbiter.sv
// complex_mult_arbiter
//   Shares one external complex multiplier (fixed MULT_LAT-cycle pipeline,
//   no reset, no backpressure) between NUM_REQ requesters. One operand set is
//   accepted per cycle via valid/ready. A requester tag travels alongside the
//   multiplier pipeline, and the product is returned on a shared response bus
//   with a one-hot strobe.
//
//   Build option: CMARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins
//     undefined -> round-robin starting after the last granted requester
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   halt                  block new grants; in-flight work drains
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_ar/ai/br/bi       packed operands, requester k at [k*WIDTH +: WIDTH]
//   m_ab_valid, m_ar..bi  registered operand issue to the multiplier
//   m_p_valid, m_pr/pi    multiplier result
//   rsp_valid/id/pr/pi    registered response (one-hot strobe, tag, product)
//   inflight              operations issued but not yet responded
//   idle                  nothing in flight and nothing to grant
//   err                   sticky tag/valid misalignment
module complex_mult_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MULT_LAT = 6,
  parameter int unsigned ID_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_ar,
  input  logic [NUM_REQ*WIDTH-1:0] req_ai,
  input  logic [NUM_REQ*WIDTH-1:0] req_br,
  input  logic [NUM_REQ*WIDTH-1:0] req_bi,
  output logic                     m_ab_valid,
  output logic [WIDTH-1:0]         m_ar,
  output logic [WIDTH-1:0]         m_ai,
  output logic [WIDTH-1:0]         m_br,
  output logic [WIDTH-1:0]         m_bi,
  input  logic                     m_p_valid,
  input  logic [2*WIDTH:0]         m_pr,
  input  logic [2*WIDTH:0]         m_pi,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH:0]         rsp_pr,
  output logic [2*WIDTH:0]         rsp_pi,
  output logic [3:0]               inflight,
  output logic                     idle,
  output logic                     err
);

  localparam int unsigned        MASK_W    = $clog2(MULT_LAT + 2);
  localparam logic [MASK_W-1:0]  MASK_DONE = MASK_W'(MULT_LAT + 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  logic                     m_ab_valid_q, m_ab_valid_d;
  logic [WIDTH-1:0]         m_ar_q, m_ar_d, m_ai_q, m_ai_d;
  logic [WIDTH-1:0]         m_br_q, m_br_d, m_bi_q, m_bi_d;
  logic [ID_W-1:0]          issue_id_q, issue_id_d;
  logic [MULT_LAT-1:0]            tag_v_q, tag_v_d;
  logic [MULT_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [2*WIDTH:0]         rsp_pr_q, rsp_pr_d, rsp_pi_q, rsp_pi_d;
  logic [3:0]               inflight_q, inflight_d;
  logic                     err_q, err_d;
  logic [MASK_W-1:0]        mask_cnt_q, mask_cnt_d;
`ifndef CMARB_FIXED_PRIO_EN
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
`endif

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               transfer;
  logic               tag_v_out;
  logic [ID_W-1:0]    tag_id_out;
  logic               rsp_fire;
  logic               chk_en;

  // Arbitration
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    if (rst_n && !halt) begin
`ifdef CMARB_FIXED_PRIO_EN
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && (((req_valid >> k) & ONE) != '0)) begin
          found    = 1'b1;
          grant_id = ID_W'(k);
        end
      end
`else
      // Two ascending passes: indices above last_grant first, then wrap to
      // 0..last_grant. Equivalent to a modulo search from last_grant+1.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && (((req_valid >> k) & ONE) != '0) &&
            (ID_W'(k) > last_grant_q)) begin
          found    = 1'b1;
          grant_id = ID_W'(k);
        end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && (((req_valid >> k) & ONE) != '0) &&
            (ID_W'(k) <= last_grant_q)) begin
          found    = 1'b1;
          grant_id = ID_W'(k);
        end
      end
`endif
    end
    grant_oh = found ? (ONE << grant_id) : '0;
  end

  assign req_ready = grant_oh;
  assign transfer  = |(req_valid & grant_oh);

  // Issue, tag pipe, response, bookkeeping
  assign tag_v_out  = tag_v_q[MULT_LAT-1];
  assign tag_id_out = tag_id_q[MULT_LAT-1];
  assign chk_en     = (mask_cnt_q == MASK_DONE);
  assign rsp_fire   = m_p_valid & tag_v_out;

  always_comb begin
    m_ab_valid_d = transfer;
    m_ar_d       = m_ar_q;
    m_ai_d       = m_ai_q;
    m_br_d       = m_br_q;
    m_bi_d       = m_bi_q;
    issue_id_d   = issue_id_q;
    if (transfer) begin
      m_ar_d     = WIDTH'(req_ar >> (grant_id * WIDTH));
      m_ai_d     = WIDTH'(req_ai >> (grant_id * WIDTH));
      m_br_d     = WIDTH'(req_br >> (grant_id * WIDTH));
      m_bi_d     = WIDTH'(req_bi >> (grant_id * WIDTH));
      issue_id_d = grant_id;
    end

    tag_v_d  = {tag_v_q[MULT_LAT-2:0], m_ab_valid_q};
    tag_id_d = {tag_id_q[MULT_LAT-2:0], issue_id_q};

    rsp_valid_d = rsp_fire ? (ONE << tag_id_out) : '0;
    rsp_id_d    = rsp_fire ? tag_id_out : rsp_id_q;
    rsp_pr_d    = rsp_fire ? m_pr : rsp_pr_q;
    rsp_pi_d    = rsp_fire ? m_pi : rsp_pi_q;

    // The multiplier is not reset, so its valid may be garbage until the
    // cleared tag pipe has had time to line up with it.
    mask_cnt_d = chk_en ? mask_cnt_q : mask_cnt_q + MASK_W'(1);
    err_d      = err_q | (chk_en & (m_p_valid ^ tag_v_out));

    inflight_d = inflight_q;
    if (transfer && (rsp_valid_q == '0) && (inflight_q != '1))
      inflight_d = inflight_q + 4'd1;
    else if (!transfer && (rsp_valid_q != '0) && (inflight_q != '0))
      inflight_d = inflight_q - 4'd1;

`ifndef CMARB_FIXED_PRIO_EN
    last_grant_d = transfer ? grant_id : last_grant_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_ab_valid_q <= 1'b0;
      m_ar_q       <= '0;
      m_ai_q       <= '0;
      m_br_q       <= '0;
      m_bi_q       <= '0;
      issue_id_q   <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_id_q     <= '0;
      rsp_pr_q     <= '0;
      rsp_pi_q     <= '0;
      inflight_q   <= '0;
      err_q        <= 1'b0;
      mask_cnt_q   <= '0;
`ifndef CMARB_FIXED_PRIO_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      m_ab_valid_q <= m_ab_valid_d;
      m_ar_q       <= m_ar_d;
      m_ai_q       <= m_ai_d;
      m_br_q       <= m_br_d;
      m_bi_q       <= m_bi_d;
      issue_id_q   <= issue_id_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_pr_q     <= rsp_pr_d;
      rsp_pi_q     <= rsp_pi_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
      mask_cnt_q   <= mask_cnt_d;
`ifndef CMARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m_ab_valid = m_ab_valid_q;
  assign m_ar       = m_ar_q;
  assign m_ai       = m_ai_q;
  assign m_br       = m_br_q;
  assign m_bi       = m_bi_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_pr     = rsp_pr_q;
  assign rsp_pi     = rsp_pi_q;
  assign inflight   = inflight_q;
  assign err        = err_q;
  assign idle       = !rst_n | ((inflight_q == '0) & (halt | (req_valid == '0)));

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench for complex_mult_arbiter with a 6-stage complex multiplier
// model standing in for the external DSP block.
module tb_complex_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, halt;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_ar, req_ai, req_br, req_bi;
  logic        m_ab_valid;
  logic [15:0] m_ar, m_ai, m_br, m_bi;
  logic        m_p_valid;
  logic [32:0] m_pr, m_pi;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [32:0] rsp_pr, rsp_pi;
  logic [3:0]  inflight;
  logic        idle, err;
  logic        force_pv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  complex_mult_arbiter #(
    .WIDTH   (16),
    .NUM_REQ (4),
    .MULT_LAT(6),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt      (halt),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ar    (req_ar),
    .req_ai    (req_ai),
    .req_br    (req_br),
    .req_bi    (req_bi),
    .m_ab_valid(m_ab_valid),
    .m_ar      (m_ar),
    .m_ai      (m_ai),
    .m_br      (m_br),
    .m_bi      (m_bi),
    .m_p_valid (m_p_valid),
    .m_pr      (m_pr),
    .m_pi      (m_pi),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_pr    (rsp_pr),
    .rsp_pi    (rsp_pi),
    .inflight  (inflight),
    .idle      (idle),
    .err       (err)
  );

  // Multiplier model: 6-cycle latency, unreset pipeline
  logic [5:0]         mv_q = '0;
  logic [32:0]        mpr_q [6];
  logic [32:0]        mpi_q [6];
  logic signed [32:0] ar_s, ai_s, br_s, bi_s;

  always_comb begin
    ar_s = {{17{m_ar[15]}}, m_ar};
    ai_s = {{17{m_ai[15]}}, m_ai};
    br_s = {{17{m_br[15]}}, m_br};
    bi_s = {{17{m_bi[15]}}, m_bi};
  end

  always @(posedge clk) begin
    mv_q     <= {mv_q[4:0], m_ab_valid};
    mpr_q[0] <= ar_s * br_s - ai_s * bi_s;
    mpi_q[0] <= ar_s * bi_s + ai_s * br_s;
    for (int i = 1; i < 6; i++) begin
      mpr_q[i] <= mpr_q[i-1];
      mpi_q[i] <= mpi_q[i-1];
    end
  end

  assign m_p_valid = mv_q[5] | force_pv;
  assign m_pr      = mpr_q[5];
  assign m_pi      = mpi_q[5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi);
    req_ar[k*16 +: 16] = ar;
    req_ai[k*16 +: 16] = ai;
    req_br[k*16 +: 16] = br;
    req_bi[k*16 +: 16] = bi;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    halt      = 1'b0;
    force_pv  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = 0;
    while (rsp_valid == '0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int viol;
    logic [32:0] last_pr, last_pi;

    rst_n = 1'b0; halt = 1'b0; force_pv = 1'b0;
    req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0;
    req_valid = 4'b0001;
    set_ops(0, 16'd3, 16'd4, 16'd5, 16'hFFFE);
    repeat (3) @(negedge clk);
    #1;

    // Reset state (req_valid held high to show ready is gated)
    check("rst_req_ready", 64'(req_ready), 64'(4'b0000));
    check("rst_m_ab_valid", 64'(m_ab_valid), 64'(1'b0));
    check("rst_m_ar", 64'(m_ar), 64'(16'd0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    check("rst_rsp_pr", 64'(rsp_pr), 64'(33'd0));
    check("rst_inflight", 64'(inflight), 64'(4'd0));
    check("rst_err", 64'(err), 64'(1'b0));
    check("rst_idle", 64'(idle), 64'(1'b1));

    // T1: single transaction on requester 0
    rst_n = 1'b1; #1;
    check("t1_ready_same_cycle", 64'(req_ready), 64'(4'b0001));
    @(negedge clk); req_valid = '0; #1;
    check("t1_m_ab_valid", 64'(m_ab_valid), 64'(1'b1));
    check("t1_m_ar", 64'(m_ar), 64'(16'd3));
    check("t1_m_ai", 64'(m_ai), 64'(16'd4));
    check("t1_m_br", 64'(m_br), 64'(16'd5));
    check("t1_m_bi", 64'(m_bi), 64'(16'hFFFE));
    check("t1_inflight", 64'(inflight), 64'(4'd1));
    @(negedge clk);
    check("t1_ab_pulse", 64'(m_ab_valid), 64'(1'b0));
    wait_rsp(20, n);
    check("t1_latency", 64'(n + 2), 64'(8));
    check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("t1_rsp_id", 64'(rsp_id), 64'(2'd0));
    check("t1_rsp_pr", 64'(rsp_pr), 64'(33'd23));
    check("t1_rsp_pi", 64'(rsp_pi), 64'(33'd14));
    @(negedge clk);
    check("t1_rsp_one_cycle", 64'(rsp_valid), 64'(4'b0000));
    check("t1_inflight_end", 64'(inflight), 64'(4'd0));
    check("t1_idle_end", 64'(idle), 64'(1'b1));

    // T2: all four requesting, round-robin at full throughput
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, 16'(k + 1), 16'd0, 16'd1, 16'd0);
    rst_n = 1'b1; req_valid = 4'hF; #1;
    for (int i = 0; i < 8; i++) begin
      check("t2_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      @(negedge clk);
      if (i == 7) req_valid = '0;
      #1;
    end
    check("t2_inflight_peak", 64'(inflight), 64'(4'd8));
    for (int j = 0; j < 8; j++) begin
      check("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << (j % 4)));
      check("t2_rsp_id", 64'(rsp_id), 64'(j % 4));
      check("t2_rsp_pr", 64'(rsp_pr), 64'((j % 4) + 1));
      check("t2_rsp_pi", 64'(rsp_pi), 64'(33'd0));
      @(negedge clk);
    end
    check("t2_inflight_end", 64'(inflight), 64'(4'd0));
    check("t2_idle_end", 64'(idle), 64'(1'b1));

    // T3: two requesters alternate with no idle cycle
    req_valid = 4'b0101; #1;
    for (int i = 0; i < 6; i++) begin
      check("t3_grant", 64'(req_ready), (i % 2 == 1) ? 64'(4'b0100) : 64'(4'b0001));
      @(negedge clk);
      if (i == 5) req_valid = '0;
      #1;
    end
    repeat (12) @(negedge clk);
    check("t3_inflight_end", 64'(inflight), 64'(4'd0));

    // T4: stream on requester 1, halt after the third accept
    set_ops(1, 16'd7, 16'd1, 16'd2, 16'd3);
    req_valid = 4'b0010; #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_grant", 64'(req_ready), 64'(4'b0010));
      @(negedge clk);
      if (i == 2) halt = 1'b1;
      #1;
    end
    check("t4_halt_ready", 64'(req_ready), 64'(4'b0000));
    check("t4_inflight", 64'(inflight), 64'(4'd3));
    check("t4_busy", 64'(idle), 64'(1'b0));
    cnt = 0; viol = 0; last_pr = '0; last_pi = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1;
      if (req_ready != '0) viol++;
      if (rsp_valid != '0) begin
        cnt++;
        last_pr = rsp_pr;
        last_pi = rsp_pi;
      end
    end
    check("t4_rsp_count", 64'(cnt), 64'(3));
    check("t4_ready_during_halt", 64'(viol), 64'(0));
    check("t4_rsp_pr", 64'(last_pr), 64'(33'd11));
    check("t4_rsp_pi", 64'(last_pi), 64'(33'd23));
    check("t4_idle", 64'(idle), 64'(1'b1));
    halt = 1'b0; req_valid = '0;

    // T5: stray m_p_valid long after reset sets sticky err
    do_reset();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_err_before", 64'(err), 64'(1'b0));
    force_pv = 1'b1;
    @(negedge clk);
    force_pv = 1'b0;
    check("t5_err_set", 64'(err), 64'(1'b1));
    check("t5_rsp_suppressed", 64'(rsp_valid), 64'(4'b0000));
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    check("t5_no_rsp", 64'(cnt), 64'(0));
    check("t5_err_sticky", 64'(err), 64'(1'b1));

    // T5b: stray valid inside the post-reset mask window is ignored
    do_reset();
    rst_n = 1'b1; force_pv = 1'b1;
    repeat (7) @(negedge clk);
    force_pv = 1'b0;
    repeat (3) @(negedge clk);
    check("t5b_err_masked", 64'(err), 64'(1'b0));
    check("t5b_rsp", 64'(rsp_valid), 64'(4'b0000));

    // T6: most-negative operands, 33-bit product without overflow
    set_ops(2, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    req_valid = 4'b0100; #1;
    check("t6_grant", 64'(req_ready), 64'(4'b0100));
    @(negedge clk); req_valid = '0;
    wait_rsp(20, n);
    check("t6_latency", 64'(n + 1), 64'(8));
    check("t6_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("t6_rsp_id", 64'(rsp_id), 64'(2'd2));
    check("t6_rsp_pr", 64'(rsp_pr), 64'(33'd0));
    check("t6_rsp_pi", 64'(rsp_pi), 64'(33'h0_8000_0000));

    // T7: reset with three operations in flight discards them
    @(negedge clk);
    set_ops(0, 16'd1, 16'd1, 16'd1, 16'd1);
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    check("t7_inflight_pre", 64'(inflight), 64'(4'd3));
    do_reset();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    check("t7_no_rsp", 64'(cnt), 64'(0));
    check("t7_inflight", 64'(inflight), 64'(4'd0));
    check("t7_err", 64'(err), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
